// File: rtl/bios_ctl_pkg.sv
// Register map, WDCTRL bit positions and FSM encoding shared by the BIOS boot watchdog.
package bios_ctl_pkg;

    localparam logic [7:0] ADDR_WDCTRL    = 8'h04 + 8'h01;
    localparam logic [7:0] ADDR_WDTIMEOUT = 8'h06;
    localparam logic [7:0] ADDR_WDSTATUS  = 8'h07;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_KICK       = 1;
    localparam int CTRL_BOOTDONE   = 2;
    localparam int CTRL_SWSWAP     = 3;
    localparam int CTRL_CLEARFAIL  = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COUNT   = 3'd1,
        ST_SWAP    = 3'd2,
        ST_HOSTRST = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAIL    = 3'd5
    } wd_state_e;

    function automatic logic [7:0] status_byte(input wd_state_e st, input logic [1:0] retry,
                                               input logic fail, input logic swap_dis,
                                               input logic en);
        return {st, retry, fail, swap_dis, en};
    endfunction

endpackage

// File: rtl/wd_tick_prescaler.sv
// Divides the LPC clock down to the watchdog tick; one-cycle tick on each wrap.
module wd_tick_prescaler #(
    parameter int TICK_DIV = 3300000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bios_boot_watchdog.sv
// Boot watchdog: times each host boot and, on timeout, pulses a BIOS swap and
// holds a host reset so the platform reboots from the other flash.
module bios_boot_watchdog
    import bios_ctl_pkg::*;
#(
    parameter int         TICK_DIV        = 3300000,
    parameter logic [7:0] DEFAULT_TIMEOUT = 8'd50,
    parameter int         MAX_RETRY       = 2,
    parameter int         RST_HOLD        = 16
) (
    input  logic       LpcClock,
    input  logic       Reset,
    input  logic       MainReset,
    input  logic       Write,
    input  logic [7:0] RegAddress,
    input  logic [7:0] DataWr,
    output logic [7:0] DataRd,
    output logic [1:0] ForceSwap,
    output logic       SwapDisable,
    output logic       HostResetReq,
    output logic       WdFail
);

    localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);

    wd_state_e         state_q, state_d;
    logic [1:0]        mr_hist_q, mr_hist_d;
    logic              enable_q, enable_d;
    logic [7:0]        timeout_q, timeout_d;
    logic [7:0]        tick_cnt_q, tick_cnt_d;
    logic [1:0]        retry_q, retry_d;
    logic              wd_fail_q, wd_fail_d;
    logic              sw_src_q, sw_src_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic mr_rise, mr_fall, wr_ctrl, wr_timeout;
    logic kick, boot_done, sw_swap, clear_fail;
    logic tick, expiry, enter_count;

    assign mr_rise     = (mr_hist_q == 2'b01);
    assign mr_fall     = (mr_hist_q == 2'b10);
    assign wr_ctrl     = Write && (RegAddress == ADDR_WDCTRL);
    assign wr_timeout  = Write && (RegAddress == ADDR_WDTIMEOUT);
    assign kick        = wr_ctrl && DataWr[CTRL_KICK];
    assign boot_done   = wr_ctrl && DataWr[CTRL_BOOTDONE];
    assign sw_swap     = wr_ctrl && DataWr[CTRL_SWSWAP];
    assign clear_fail  = wr_ctrl && DataWr[CTRL_CLEARFAIL];
    // A zero timeout disables expiry entirely.
    assign expiry      = tick && (timeout_q != 8'd0) && (tick_cnt_q == timeout_q - 8'd1);
    assign enter_count = (state_q != ST_COUNT) && (state_d == ST_COUNT);

    wd_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk    (LpcClock),
        .rst    (Reset),
        .clear  (enter_count || kick),
        .enable (state_q == ST_COUNT),
        .tick   (tick)
    );

    always_ff @(posedge LpcClock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mr_rise && enable_q && !wd_fail_q) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (mr_fall)         state_d = ST_IDLE;
                else if (boot_done)  state_d = ST_DONE;
                else if (kick)       state_d = ST_COUNT;
                else if (sw_swap)    state_d = ST_SWAP;
                else if (expiry)     state_d = (retry_q == RETRY_MAX) ? ST_FAIL : ST_SWAP;
                else if (!enable_q)  state_d = ST_IDLE;
            end
            ST_SWAP:    state_d = ST_HOSTRST;
            ST_HOSTRST: begin
                if (hold_q == HOLD_LAST) state_d = ST_IDLE;
            end
            ST_DONE: begin
                if (mr_fall) state_d = ST_IDLE;
            end
            ST_FAIL: begin
                if (clear_fail) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mr_hist_d  = {mr_hist_q[0], MainReset};
        enable_d   = wr_ctrl ? DataWr[CTRL_ENABLE] : enable_q;
        timeout_d  = wr_timeout ? DataWr : timeout_q;
        hold_d     = (state_q == ST_HOSTRST) ? hold_q + 1'b1 : '0;
        tick_cnt_d = tick_cnt_q;
        if (enter_count || kick) begin
            tick_cnt_d = '0;
        end else if ((state_q == ST_COUNT) && tick) begin
            tick_cnt_d = tick_cnt_q + 8'd1;
        end
        // sw_swap can only reach SWAP by winning over expiry, so it names the source.
        sw_src_d = sw_src_q;
        if ((state_q == ST_COUNT) && (state_d == ST_SWAP)) sw_src_d = sw_swap;
        retry_d   = retry_q;
        wd_fail_d = wd_fail_q;
        if (clear_fail) begin
            retry_d   = '0;
            wd_fail_d = 1'b0;
        end else if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
            retry_d = '0;
        end else if ((state_q == ST_COUNT) && (state_d == ST_SWAP) && !sw_swap) begin
            if (retry_q != RETRY_MAX) retry_d = retry_q + 2'd1;
        end else if ((state_q == ST_COUNT) && (state_d == ST_FAIL)) begin
            wd_fail_d = 1'b1;
        end
    end

    always_ff @(posedge LpcClock) begin
        if (Reset) begin
            mr_hist_q  <= 2'b00;
            enable_q   <= 1'b0;
            timeout_q  <= DEFAULT_TIMEOUT;
            tick_cnt_q <= '0;
            retry_q    <= '0;
            wd_fail_q  <= 1'b0;
            sw_src_q   <= 1'b0;
            hold_q     <= '0;
        end else begin
            mr_hist_q  <= mr_hist_d;
            enable_q   <= enable_d;
            timeout_q  <= timeout_d;
            tick_cnt_q <= tick_cnt_d;
            retry_q    <= retry_d;
            wd_fail_q  <= wd_fail_d;
            sw_src_q   <= sw_src_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        ForceSwap = 2'b00;
        if (state_q == ST_SWAP) ForceSwap = sw_src_q ? 2'b10 : 2'b01;
        SwapDisable  = (state_q == ST_DONE);
        HostResetReq = (state_q == ST_HOSTRST);
        WdFail       = wd_fail_q;
        case (RegAddress)
            ADDR_WDCTRL:    DataRd = {7'b0, enable_q};
            ADDR_WDTIMEOUT: DataRd = timeout_q;
            ADDR_WDSTATUS:  DataRd = status_byte(state_q, retry_q, wd_fail_q, SwapDisable, enable_q);
            default:        DataRd = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_bios_boot_watchdog.sv
// Self-checking bench for bios_boot_watchdog: register vectors plus boot/swap sequences.
module tb_bios_boot_watchdog;

    logic       LpcClock = 1'b0;
    logic       Reset = 1'b1;
    logic       MainReset = 1'b0;
    logic       Write = 1'b0;
    logic [7:0] RegAddress = 8'h00;
    logic [7:0] DataWr = 8'h00;
    logic [7:0] DataRd;
    logic [1:0] ForceSwap;
    logic       SwapDisable;
    logic       HostResetReq;
    logic       WdFail;

    always #5 LpcClock = ~LpcClock;

    bios_boot_watchdog #(
        .TICK_DIV        (4),
        .DEFAULT_TIMEOUT (8'd50),
        .MAX_RETRY       (2),
        .RST_HOLD        (16)
    ) dut (
        .LpcClock     (LpcClock),
        .Reset        (Reset),
        .MainReset    (MainReset),
        .Write        (Write),
        .RegAddress   (RegAddress),
        .DataWr       (DataWr),
        .DataRd       (DataRd),
        .ForceSwap    (ForceSwap),
        .SwapDisable  (SwapDisable),
        .HostResetReq (HostResetReq),
        .WdFail       (WdFail)
    );

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge LpcClock);
            #1;
        end
    endtask

    task automatic sb_push(input string name, input logic [7:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [7:0] act);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty actual=%h", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
            end
        end
    endtask

    // Output pins packed as {3'b0, WdFail, SwapDisable, HostResetReq, ForceSwap[1:0]}.
    function automatic logic [7:0] outs();
        return {3'b0, WdFail, SwapDisable, HostResetReq, ForceSwap};
    endfunction

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        Write = 1'b1;
        RegAddress = a;
        DataWr = d;
        @(posedge LpcClock);
        #1;
        Write = 1'b0;
        DataWr = 8'h00;
    endtask

    task automatic chk_rd(input string name, input logic [7:0] a, input logic [7:0] exp);
        RegAddress = a;
        sb_push(name, exp);
        @(negedge LpcClock);
        sb_check(DataRd);
        @(posedge LpcClock);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [7:0] exp);
        sb_push(name, exp);
        sb_check(outs());
    endtask

    // Expected pin trace over the next n cycles, queued before the cycles run.
    task automatic run_trace(input string tag, input int n, input int pulse_k,
                             input logic [1:0] pulse_v, input int hr_first, input int hr_last,
                             input int sd_first, input int sd_last, input int fail_from);
        for (int k = 1; k <= n; k++) begin
            sb_push($sformatf("%s_k%0d", tag, k),
                    {3'b0, (k >= fail_from), (k >= sd_first && k <= sd_last),
                     (k >= hr_first && k <= hr_last), (k == pulse_k) ? pulse_v : 2'b00});
        end
        for (int k = 1; k <= n; k++) begin
            @(posedge LpcClock);
            #1;
            sb_check(outs());
        end
    endtask

    task automatic new_boot();
        MainReset = 1'b0;
        cyc(3);
        MainReset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int nz;

        vecs[0]  = '{1'b0, 8'h06, 8'h00, 8'd50};
        vecs[1]  = '{1'b0, 8'h07, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 8'h05, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 8'h07, 8'hFF, 8'h00};
        vecs[4]  = '{1'b0, 8'h07, 8'h00, 8'h00};
        vecs[5]  = '{1'b1, 8'h06, 8'h03, 8'h00};
        vecs[6]  = '{1'b0, 8'h06, 8'h00, 8'h03};
        vecs[7]  = '{1'b1, 8'h05, 8'h01, 8'h00};
        vecs[8]  = '{1'b0, 8'h05, 8'h00, 8'h01};
        vecs[9]  = '{1'b0, 8'h07, 8'h00, 8'h01};
        vecs[10] = '{1'b0, 8'h08, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 8'h04, 8'h00, 8'h00};

        Reset = 1'b1;
        cyc(3);
        chk_out("rst_outs", 8'h00);
        Reset = 1'b0;
        cyc(1);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
            else chk_rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // SwSwap and BootDone have no effect outside COUNT.
        wr(8'h05, 8'h09);
        chk_out("sw_idle_ignored", 8'h00);
        wr(8'h05, 8'h05);
        chk_rd("bd_idle_ignored", 8'h07, 8'h01);

        // Unserviced boot: COUNT entered 2 cycles after the rise, swap 12 cycles later.
        MainReset = 1'b1;
        run_trace("tmo", 31, 14, 2'b01, 15, 30, 0, -1, 1000);
        chk_rd("tmo_status", 8'h07, 8'h09);

        // BootDone at tick count 2.
        new_boot();
        run_trace("bd_pre", 10, 0, 2'b00, 0, -1, 0, -1, 1000);
        wr(8'h05, 8'h05);
        chk_out("bd_sd", 8'h08);
        run_trace("bd_hold", 8, 0, 2'b00, 0, -1, 1, 8, 1000);
        chk_rd("bd_status", 8'h07, 8'h83);
        MainReset = 1'b0;
        run_trace("bd_fall", 2, 0, 2'b00, 0, -1, 1, 1, 1000);
        chk_rd("bd_after", 8'h07, 8'h01);

        // Retry budget: two swaps, then FAIL without a pulse.
        for (int b = 0; b < 2; b++) begin
            new_boot();
            run_trace($sformatf("boot%0d", b), 31, 14, 2'b01, 15, 30, 0, -1, 1000);
            chk_rd($sformatf("boot%0d_status", b), 8'h07, (b == 0) ? 8'h09 : 8'h11);
        end
        new_boot();
        run_trace("boot2", 20, 0, 2'b00, 0, -1, 0, -1, 14);
        chk_rd("fail_status", 8'h07, 8'hB5);
        wr(8'h05, 8'h81);
        chk_out("clr_outs", 8'h00);
        chk_rd("clr_status", 8'h07, 8'h01);

        // Kick lands in the expiry cycle: counting restarts from zero.
        new_boot();
        run_trace("kick_pre", 13, 0, 2'b00, 0, -1, 0, -1, 1000);
        wr(8'h05, 8'h03);
        run_trace("kick_post", 29, 12, 2'b01, 13, 28, 0, -1, 1000);
        chk_rd("kick_status", 8'h07, 8'h09);

        // Zero timeout never expires.
        wr(8'h06, 8'h00);
        new_boot();
        nz = 0;
        for (int i = 0; i < 4010; i++) begin
            cyc(1);
            if (ForceSwap != 2'b00 || HostResetReq) nz++;
        end
        sb_push("tmo0_no_expiry", 8'h00);
        sb_check((nz > 255) ? 8'hFF : 8'(nz));
        chk_rd("tmo0_status", 8'h07, 8'h29);
        chk_rd("tmo0_reg", 8'h06, 8'h00);

        // Software swap, then reset in the middle of HOSTRST.
        wr(8'h05, 8'h09);
        chk_out("sw_pulse", 8'h02);
        run_trace("sw_hr", 3, 0, 2'b00, 1, 3, 0, -1, 1000);
        chk_rd("sw_status", 8'h07, 8'h69);
        Reset = 1'b1;
        cyc(1);
        chk_out("rst_hr_drop", 8'h00);
        chk_rd("rst_tmo", 8'h06, 8'd50);
        chk_rd("rst_status", 8'h07, 8'h00);
        chk_rd("rst_ctrl", 8'h05, 8'h00);
        Reset = 1'b0;
        cyc(2);
        chk_rd("post_rst_status", 8'h07, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
